// File: rtl/updown_count_decoder.sv
// Recovers count direction from sampled up/down counter values,
// locks after a run of legal steps and counts illegal jumps.
module updown_count_decoder #(
    parameter int WIDTH    = 3,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] q_in,
    input  logic             valid_in,
    output logic             dir_out,
    output logic             dir_valid,
    output logic             step_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             locked
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQ,
        S_LOCK
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_prev;
    logic [RUN_W-1:0]   r_run;
    logic [RUN_W-1:0]   w_run_nxt;
    logic [RUN_W-1:0]   w_run_inc;
    logic               r_dir;
    logic               r_dv;
    logic               r_se;
    logic [ERR_W-1:0]   r_err_cnt;
    logic               r_locked;

    logic [WIDTH-1:0]   w_delta;
    logic               w_up;
    logic               w_dn;
    logic               w_hold;
    logic               w_err;
    logic               w_dir_nxt;
    logic               w_dv_nxt;
    logic               w_se_nxt;
    logic [ERR_W-1:0]   w_err_cnt_nxt;

    // Modular subtraction makes wrap-around steps look like +1 / -1.
    assign w_delta   = q_in - r_prev;
    assign w_up      = (w_delta == WIDTH'(1));
    assign w_dn      = (w_delta == {WIDTH{1'b1}});
    assign w_hold    = (w_delta == '0);
    assign w_err     = !(w_up || w_dn || w_hold);
    assign w_run_inc = r_run + RUN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_prev    <= '0;
            r_run     <= '0;
            r_dir     <= 1'b1;
            r_dv      <= 1'b0;
            r_se      <= 1'b0;
            r_err_cnt <= '0;
            r_locked  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_run     <= w_run_nxt;
            r_dir     <= w_dir_nxt;
            r_dv      <= w_dv_nxt;
            r_se      <= w_se_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_locked  <= (w_state_nxt == S_LOCK);
            if (valid_in) begin
                r_prev <= q_in;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        if (valid_in) begin
            unique case (r_state)
                S_IDLE: begin
                    w_run_nxt   = '0;
                    w_state_nxt = S_ACQ;
                end
                S_ACQ: begin
                    if (w_err) begin
                        w_run_nxt = '0;
                    end else if (w_up || w_dn) begin
                        w_run_nxt = w_run_inc;
                        if (w_run_inc == RUN_W'(LOCK_CNT)) begin
                            w_state_nxt = S_LOCK;
                        end
                    end
                end
                S_LOCK: begin
                    if (w_err) begin
                        w_run_nxt   = '0;
                        w_state_nxt = S_ACQ;
                    end
                end
                default: begin
                    w_run_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_dir_nxt     = r_dir;
        w_dv_nxt      = 1'b0;
        w_se_nxt      = 1'b0;
        w_err_cnt_nxt = r_err_cnt;
        if (valid_in && r_state != S_IDLE) begin
            if (w_up || w_dn) begin
                w_dir_nxt = w_up;
                w_dv_nxt  = (r_state == S_LOCK);
            end
            if (w_err) begin
                w_se_nxt = 1'b1;
                if (r_err_cnt != {ERR_W{1'b1}}) begin
                    w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
                end
            end
        end
    end

    assign dir_out   = r_dir;
    assign dir_valid = r_dv;
    assign step_err  = r_se;
    assign err_cnt   = r_err_cnt;
    assign locked    = r_locked;

endmodule

// File: tb/tb_updown_count_decoder.sv
// Bench for updown_count_decoder: directed vector table, saturation
// and reset sequences, then random samples against a reference model.
module tb_updown_count_decoder;

    localparam int WIDTH    = 3;
    localparam int LOCK_CNT = 4;
    localparam int ERR_W    = 8;
    localparam int MASK     = (1 << WIDTH) - 1;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] q_in;
    logic             valid_in;
    logic             dir_out;
    logic             dir_valid;
    logic             step_err;
    logic [ERR_W-1:0] err_cnt;
    logic             locked;

    int checks = 0;
    int errors = 0;

    updown_count_decoder #(
        .WIDTH   (WIDTH),
        .LOCK_CNT(LOCK_CNT),
        .ERR_W   (ERR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .q_in     (q_in),
        .valid_in (valid_in),
        .dir_out  (dir_out),
        .dir_valid(dir_valid),
        .step_err (step_err),
        .err_cnt  (err_cnt),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             r;
        logic             v;
        logic [WIDTH-1:0] q;
        logic             dir;
        logic             dv;
        logic             se;
        int               err;
        logic             lk;
    } vec_t;

    vec_t tbl[$];

    // Reference model state, kept as plain numbers and flags.
    bit m_started;
    bit m_locked;
    int m_run;
    int m_prev;
    bit m_dir;
    bit m_dv;
    bit m_se;
    int m_err;

    function automatic vec_t mk(logic r, logic v, int q,
                                logic d, logic dv, logic se,
                                int e, logic lk);
        vec_t t;
        t.r   = r;
        t.v   = v;
        t.q   = q[WIDTH-1:0];
        t.dir = d;
        t.dv  = dv;
        t.se  = se;
        t.err = e;
        t.lk  = lk;
        return t;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic d, logic dv, logic se,
                           int e, logic lk);
        chk({tag, ".dir_out"}, int'(dir_out), int'(d));
        chk({tag, ".dir_valid"}, int'(dir_valid), int'(dv));
        chk({tag, ".step_err"}, int'(step_err), int'(se));
        chk({tag, ".err_cnt"}, int'(err_cnt), e);
        chk({tag, ".locked"}, int'(locked), int'(lk));
    endtask

    task automatic step(input logic r, input logic v, input int q);
        rst      = r;
        valid_in = v;
        q_in     = q[WIDTH-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic model(input bit r, input bit v, input int q);
        int d;
        if (r) begin
            m_started = 0;
            m_locked  = 0;
            m_run     = 0;
            m_prev    = 0;
            m_dir     = 1;
            m_dv      = 0;
            m_se      = 0;
            m_err     = 0;
            return;
        end
        m_dv = 0;
        m_se = 0;
        if (!v) return;
        d = (q - m_prev) & MASK;
        if (!m_started) begin
            m_started = 1;
            m_run     = 0;
        end else if (d == 1 || d == MASK) begin
            m_dir = (d == 1);
            if (m_locked) begin
                m_dv = 1;
            end else begin
                m_run++;
                if (m_run == LOCK_CNT) m_locked = 1;
            end
        end else if (d != 0) begin
            m_se     = 1;
            m_err    = (m_err < ERR_MAX) ? m_err + 1 : m_err;
            m_run    = 0;
            m_locked = 0;
        end
        m_prev = q;
    endtask

    initial begin
        int exp_err;
        int q;
        bit r;
        bit v;

        rst      = 1'b1;
        valid_in = 1'b0;
        q_in     = '0;

        // Reset, acquire on 0..4, first locked step on 5.
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 5, 1, 1, 0, 0, 1));
        // Locked wrap-around and reversal.
        tbl.push_back(mk(0, 1, 6, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 7, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 7, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 6, 0, 1, 0, 0, 1));
        // Hold then illegal jump drops lock.
        tbl.push_back(mk(0, 1, 6, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 2, 0, 0, 1, 1, 0));
        // ACQ hold keeps run; reacquire ending on 3.
        tbl.push_back(mk(0, 1, 3, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 3, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 4, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 5, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 4, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 3, 0, 1, 0, 1, 1));
        // Repeated 3 with gaps; q ignored when valid_in is low.
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 5, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 1, 1));
        // ACQ error resets run: needs four fresh steps to lock.
        tbl.push_back(mk(0, 1, 7, 0, 0, 1, 2, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 2, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 2, 0));
        tbl.push_back(mk(0, 1, 5, 1, 0, 1, 3, 0));
        tbl.push_back(mk(0, 1, 6, 1, 0, 0, 3, 0));
        tbl.push_back(mk(0, 1, 7, 1, 0, 0, 3, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 3, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 3, 1));
        // Reset with a simultaneous sample clears everything.
        tbl.push_back(mk(1, 1, 2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 6, 1, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, int'(tbl[i].q));
            chk_all($sformatf("vec%0d", i), tbl[i].dir, tbl[i].dv,
                    tbl[i].se, tbl[i].err, tbl[i].lk);
        end

        // Saturation: 300 alternating illegal samples after reset.
        step(1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            step(0, 1, (i % 2) ? 4 : 0);
            exp_err = (i < ERR_MAX) ? i : ERR_MAX;
            chk($sformatf("sat%0d.err_cnt", i), int'(err_cnt), exp_err);
            chk($sformatf("sat%0d.step_err", i), int'(step_err),
                (i == 0) ? 0 : 1);
        end
        chk("sat.final", int'(err_cnt), ERR_MAX);
        step(1, 0, 0);
        chk_all("sat_rst", 1, 0, 0, 0, 0);

        // Random samples against the reference model.
        model(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 9) < 8);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: q = (m_prev + 1) & MASK;
                4, 5, 6:    q = (m_prev + MASK) & MASK;
                7:          q = m_prev;
                default:    q = int'($urandom_range(0, MASK));
            endcase
            model(r, v, q);
            step(r, v, q);
            chk_all($sformatf("rnd%0d", i), m_dir, m_dv, m_se,
                    m_err, m_locked);
            chk($sformatf("rnd%0d.excl", i),
                int'(dir_valid & step_err), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_count_decoder.md
UPDOWN_COUNT_DECODER -- requirements
Module: updown_count_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3: width of the observed count.
REQ-002 The block SHALL have parameter LOCK_CNT, default 4: number of consecutive legal steps needed to reach LOCK.
REQ-003 The block SHALL have parameter ERR_W, default 8: width of the error counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port q_in, input, WIDTH bits: sampled count value from an up/down counter.
REQ-007 The block SHALL have port valid_in, input, 1 bit: q_in is a new sample this cycle.
REQ-008 The block SHALL have port dir_out, output, 1 bit: recovered direction, 1 = up, 0 = down.
REQ-009 The block SHALL have port dir_valid, output, 1 bit: one-cycle pulse, dir_out updated from a legal step while locked.
REQ-010 The block SHALL have port step_err, output, 1 bit: one-cycle pulse, illegal step detected.
REQ-011 The block SHALL have port err_cnt, output, ERR_W bits: saturating count of illegal steps.
REQ-012 The block SHALL have port locked, output, 1 bit: high while the state machine is in LOCK.

Function
REQ-013 The block SHALL hold internal registers prev (WIDTH bits) and run (counts 0..LOCK_CNT), plus a state machine with states IDLE, ACQ and LOCK.
REQ-014 On each valid_in, the block SHALL compute delta = (q_in - prev) mod 2^WIDTH and classify it: delta=1 is UP; delta=all-ones is DOWN; delta=0 is HOLD; any other value is ERR.
REQ-015 Wrap-around SHALL count as a legal step: 7->0 is UP and 0->7 is DOWN (WIDTH=3).
REQ-016 In every state, any valid_in sample SHALL be written to prev.
REQ-017 IDLE + valid_in: the block SHALL capture the sample, set run=0, move to ACQ, and raise no pulses.
REQ-018 ACQ + UP/DOWN: the block SHALL increment run and set dir_out.
  - When the increment makes run equal LOCK_CNT, the block SHALL move to LOCK.
  - dir_valid SHALL NOT pulse in ACQ.
REQ-019 ACQ + HOLD: run, dir_out and state SHALL be unchanged.
REQ-020 ACQ + ERR: the block SHALL set run=0, pulse step_err, increment err_cnt, and stay in ACQ.
REQ-021 LOCK + UP/DOWN: the block SHALL update dir_out and pulse dir_valid; direction reversal is legal and does not drop lock.
REQ-022 LOCK + HOLD: the block SHALL raise no pulse and make no change.
REQ-023 LOCK + ERR: the block SHALL pulse step_err, increment err_cnt, set run=0, and move to ACQ.
REQ-024 err_cnt SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-025 All outputs SHALL be registered, with latency of exactly 1 cycle from the valid_in sample edge to the dir_valid/step_err pulse, dir_out update and locked change.
REQ-026 dir_valid and step_err SHALL never be high in the same cycle, and each SHALL be high for at most one cycle per sample.
REQ-027 With valid_in low, no state SHALL change and both pulses SHALL be low.
REQ-028 locked SHALL rise in the cycle after the LOCK_CNT-th legal step and fall in the cycle after the first ERR.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL set state=IDLE, prev=0, run=0, dir_out=1, dir_valid=0, step_err=0, err_cnt=0 and locked=0.
REQ-030 rst SHALL take priority over a simultaneous valid_in, and that sample SHALL be discarded.
REQ-031 Reset asserted mid-operation, in any state, SHALL abandon lock and clear err_cnt in the same edge; the first sample after reset SHALL be treated as an IDLE capture.

Verification
REQ-032 The bench SHALL apply rst for 2 cycles -> all outputs at reset values, locked=0, err_cnt=0.
REQ-033 The bench SHALL send samples 0,1,2,3,4,5 -> locked rises 1 cycle after sample 4, dir_valid pulses after sample 5, and dir_out=1.
REQ-034 The bench SHALL send, while locked, 6,7,0,7,6 -> dir_valid pulses on each sample, dir_out sequence 1,1,1,0,0, and locked stays 1.
REQ-035 The bench SHALL send, while locked, 6 then 2 -> step_err pulses once, err_cnt=1, and locked falls the next cycle.
REQ-036 The bench SHALL send repeated 3,3,3 while locked, with valid_in gaps -> no pulses and no state change.
REQ-037 The bench SHALL send 300 alternating illegal samples (0,4,0,4,...) with ERR_W=8 -> err_cnt saturates at 255, then rst returns err_cnt to 0.
